// File: rtl/ofdm_cp_serializer_pkg.sv
// ofdm_cp_serializer_pkg
//   Shared OFDM datapath types and constants. The complex sample type matches
//   the FFT's frame format. The CP defaults are shared with the RX CP remover.
//   The serializer FSM state encodings also live here.
package ofdm_cp_serializer_pkg;

    localparam int DATA_W = 16;

    typedef struct packed {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
    } complex_product_t;

    // Symbol geometry shared by the TX CP inserter and the RX CP remover
    localparam int OFDM_N_DEFAULT      = 32;
    localparam int OFDM_CP_LEN_DEFAULT = 8;

    // Serializer FSM: phase of the sample currently presented on data_out
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CP   = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;

endpackage

// File: rtl/ofdm_cp_serializer_if.sv
// ofdm_cp_serializer_if
//   Bundle of the frame input and the serial output handshake of the CP
//   serializer.
//   slave  : the serializer side (takes frames, drives serial samples)
//   master : the producer/consumer side (drives frames and data_ready)
//   Signals: frame_in/frame_valid/frame_ready (parallel frame in),
//            data_out/data_valid/data_ready/sof/eof/sample_idx (serial out),
//            overflow (sticky dropped-frame flag)
interface ofdm_cp_serializer_if
    import ofdm_cp_serializer_pkg::*;
#(
    parameter int N      = OFDM_N_DEFAULT,
    parameter int CP_LEN = OFDM_CP_LEN_DEFAULT,
    parameter int IDX_W  = $clog2(N + CP_LEN)
);
    complex_product_t [N-1:0] frame_in;
    logic                     frame_valid;
    logic                     frame_ready;
    complex_product_t         data_out;
    logic                     data_valid;
    logic                     data_ready;
    logic                     sof;
    logic                     eof;
    logic [IDX_W-1:0]         sample_idx;
    logic                     overflow;

    modport master (
        output frame_in, frame_valid, data_ready,
        input  frame_ready, data_out, data_valid, sof, eof, sample_idx, overflow
    );

    modport slave (
        input  frame_in, frame_valid, data_ready,
        output frame_ready, data_out, data_valid, sof, eof, sample_idx, overflow
    );

endinterface

// File: rtl/ofdm_cp_serializer_frame_bank.sv
// ofdm_frame_bank
//   Two-bank frame store for the CP serializer. A whole N-point frame is written
//   in one cycle into the selected bank, which is then marked full. A bank is
//   marked empty again through the clear port. The read port returns one
//   sample through a register. The register reloads only when rd_en is high,
//   so it also acts as the output holding register while the output stalls.
//   Ports: clk, reset (sync, active-low), wr_en/wr_sel/wr_frame (write),
//          clr_en/clr_sel (free a bank), full (per-bank flags),
//          rd_en/rd_sel/rd_addr -> rd_data (registered read)
module ofdm_frame_bank
    import ofdm_cp_serializer_pkg::*;
#(
    parameter int N  = OFDM_N_DEFAULT,
    parameter int AW = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  complex_product_t [N-1:0] wr_frame,
    input  logic                     clr_en,
    input  logic                     clr_sel,
    output logic [1:0]               full,
    input  logic                     rd_en,
    input  logic                     rd_sel,
    input  logic [AW-1:0]            rd_addr,
    output complex_product_t         rd_data
);
    complex_product_t [N-1:0] mem_q [2];
    complex_product_t [N-1:0] mem_d [2];
    logic [1:0]               full_q, full_d;
    complex_product_t         rd_data_q, rd_data_d;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) mem_d[wr_sel] = wr_frame;
    end

    // Set and clear never target the same bank: writes go only to an empty bank
    // and clears go only to a full one.
    always_comb begin
        full_d = full_q;
        if (wr_en)  full_d[wr_sel]  = 1'b1;
        if (clr_en) full_d[clr_sel] = 1'b0;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) rd_data_d = mem_q[rd_sel][rd_addr];
    end

    // Frame storage carries no reset; the full flags gate every use of it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            full_q    <= 2'b00;
            rd_data_q <= '0;
        end else begin
            full_q    <= full_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign full    = full_q;
    assign rd_data = rd_data_q;

endmodule

// File: rtl/ofdm_cp_serializer.sv
// ofdm_cp_serializer
//   Takes a whole N-point IFFT frame in one cycle. Streams the frame out one
//   complex sample per cycle with a CP_LEN-sample cyclic prefix in front. Two
//   frame banks let a new frame arrive while the previous one streams out.
//   Symbols then follow each other with no idle cycle between them.
//   Ports: clk, reset (sync, active-low),
//          bus (slave): frame_in/frame_valid/frame_ready,
//          data_out/data_valid/data_ready/sof/eof/sample_idx, overflow
module ofdm_cp_serializer
    import ofdm_cp_serializer_pkg::*;
#(
    parameter int N      = OFDM_N_DEFAULT,
    parameter int CP_LEN = OFDM_CP_LEN_DEFAULT,
    parameter int IDX_W  = $clog2(N + CP_LEN)
) (
    input logic                clk,
    input logic                reset,
    ofdm_cp_serializer_if.slave bus
);
    localparam int               AW        = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N + CP_LEN - 1);
    // Symbol position p maps to frame index (p + N - CP_LEN) mod N. This covers
    // both the prefix and the body, because N is a power of two.
    localparam logic [AW-1:0]    CP_OFFSET = AW'(N - CP_LEN);
    localparam logic [1:0]       ST_FIRST  = (CP_LEN > 0) ? ST_CP : ST_BODY;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic             overflow_q, overflow_d;

    logic [1:0]       full;
    logic             capture;
    logic             advance;
    logic             beat_last;
    logic             start_sel;
    logic             load;
    logic             rd_sel;
    logic [AW-1:0]    rd_addr;
    complex_product_t rd_data;

    assign capture   = bus.frame_valid & ~full[wr_bank_q];
    assign advance   = ~valid_q | bus.data_ready;
    assign beat_last = valid_q & bus.data_ready & eof_q;
    // A new symbol comes from rd_bank when idle. Right after an eof beat it
    // comes from the other bank, because rd_bank toggles on that same edge.
    assign start_sel = (state_q == ST_IDLE) ? rd_bank_q : ~rd_bank_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        sof_d      = sof_q;
        eof_d      = eof_q;
        wr_bank_d  = wr_bank_q ^ capture;
        rd_bank_d  = rd_bank_q ^ beat_last;
        overflow_d = overflow_q | (bus.frame_valid & full[wr_bank_q]);
        load       = 1'b0;
        rd_sel     = rd_bank_q;
        rd_addr    = '0;
        if (advance) begin
            if ((state_q == ST_IDLE) || beat_last) begin
                if (full[start_sel]) begin
                    state_d = ST_FIRST;
                    idx_d   = '0;
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    eof_d   = 1'b0;
                    load    = 1'b1;
                    rd_sel  = start_sel;
                    rd_addr = CP_OFFSET;
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    valid_d = 1'b0;
                    sof_d   = 1'b0;
                    eof_d   = 1'b0;
                end
            end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = (int'(idx_d) < CP_LEN) ? ST_CP : ST_BODY;
                valid_d = 1'b1;
                sof_d   = 1'b0;
                eof_d   = (idx_d == LAST_IDX);
                load    = 1'b1;
                rd_addr = AW'(idx_d) + CP_OFFSET;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            overflow_q <= overflow_d;
        end
    end

    ofdm_frame_bank #(.N(N), .AW(AW)) u_bank (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (capture),
        .wr_sel   (wr_bank_q),
        .wr_frame (bus.frame_in),
        .clr_en   (beat_last),
        .clr_sel  (rd_bank_q),
        .full     (full),
        .rd_en    (load),
        .rd_sel   (rd_sel),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    // Only registered state feeds frame_ready. A bank freed by an eof beat
    // therefore shows as free one cycle later.
    assign bus.frame_ready = ~full[wr_bank_q];
    assign bus.data_out    = rd_data;
    assign bus.data_valid  = valid_q;
    assign bus.sof         = sof_q;
    assign bus.eof         = eof_q;
    assign bus.sample_idx  = idx_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_ofdm_cp_serializer.sv
// Bench for ofdm_cp_serializer. One instance has N=8, CP_LEN=2 and a second
// has N=8, CP_LEN=0. Expected beats go into a queue per instance when a frame
// is driven. They are popped and compared when the DUT produces a beat.
module tb_ofdm_cp_serializer;
    import ofdm_cp_serializer_pkg::*;

    localparam int N  = 8;
    localparam int CP = 2;

    typedef complex_product_t [N-1:0] frame_t;
    typedef struct packed {
        logic signed [15:0] re;
        logic signed [15:0] im;
        logic               sof;
        logic               eof;
        logic [7:0]         idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ofdm_cp_serializer_if #(.N(N), .CP_LEN(CP)) bus ();
    ofdm_cp_serializer_if #(.N(N), .CP_LEN(0))  bus0 ();

    ofdm_cp_serializer #(.N(N), .CP_LEN(CP)) dut (.clk(clk), .reset(reset), .bus(bus));
    ofdm_cp_serializer #(.N(N), .CP_LEN(0))  dut0 (.clk(clk), .reset(reset), .bus(bus0));

    int   n_checks = 0;
    int   n_pass   = 0;
    int   rmode    = 0;     // data_ready: 0 = low, 1 = high, 2 = random
    bit   mon_on   = 1'b0;
    exp_t q[$];
    exp_t q0[$];

    function automatic frame_t make_frame(input int base);
        frame_t f;
        for (int k = 0; k < N; k++) begin
            f[k].re = 16'(base + k + 1);
            f[k].im = 16'(-(base + k + 1));
        end
        return f;
    endfunction

    task automatic push_exp(input bit which, input int base, input int cp);
        exp_t e;
        int   src;
        for (int p = 0; p < N + cp; p++) begin
            src   = (p < cp) ? (N - cp + p) : (p - cp);
            e.re  = 16'(base + src + 1);
            e.im  = 16'(-(base + src + 1));
            e.sof = (p == 0);
            e.eof = (p == N + cp - 1);
            e.idx = 8'(p);
            if (which) q0.push_back(e);
            else       q.push_back(e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
        bus.data_ready  = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
        bus0.data_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
    endtask

    task automatic drive_frame(input bit which, input int base);
        if (which) begin
            bus0.frame_in    = make_frame(base);
            bus0.frame_valid = 1'b1;
        end else begin
            bus.frame_in    = make_frame(base);
            bus.frame_valid = 1'b1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int i = 0;
        while ((q.size() != 0 || q0.size() != 0 || bus.data_valid !== 1'b0 ||
                bus0.data_valid !== 1'b0) && i < budget) begin
            tick();
            i++;
        end
        n_checks++;
        if (i >= budget)
            $display("FAIL %s_drain: %0d+%0d beats still expected after %0d cycles, required 0",
                     name, q.size(), q0.size(), budget);
        else n_pass++;
    endtask

    // Scoreboard monitor, CP_LEN=2 instance
    exp_t             me;
    logic             st_prev = 1'b0;
    complex_product_t pd;
    logic [7:0]       pidx;
    logic             psof, peof;
    always @(negedge clk) begin
        if (!mon_on) st_prev = 1'b0;
        else begin
            if (st_prev) begin
                n_checks++;
                if (bus.data_valid !== 1'b1 || bus.data_out !== pd || 8'(bus.sample_idx) !== pidx ||
                    bus.sof !== psof || bus.eof !== peof)
                    $display("FAIL stall_hold: valid=%b re=%0d idx=%0d sof=%b eof=%b, required valid=1 re=%0d idx=%0d sof=%b eof=%b",
                             bus.data_valid, bus.data_out.re, bus.sample_idx, bus.sof, bus.eof,
                             pd.re, pidx, psof, peof);
                else n_pass++;
            end
            if (bus.data_valid === 1'b1 && bus.data_ready === 1'b1) begin
                n_checks++;
                if (q.size() == 0)
                    $display("FAIL beat_unexpected: got re=%0d idx=%0d, required no beat",
                             bus.data_out.re, bus.sample_idx);
                else begin
                    me = q.pop_front();
                    if (bus.data_out.re !== me.re || bus.data_out.im !== me.im || bus.sof !== me.sof ||
                        bus.eof !== me.eof || 8'(bus.sample_idx) !== me.idx)
                        $display("FAIL beat: got re=%0d im=%0d sof=%b eof=%b idx=%0d, required re=%0d im=%0d sof=%b eof=%b idx=%0d",
                                 bus.data_out.re, bus.data_out.im, bus.sof, bus.eof, bus.sample_idx,
                                 me.re, me.im, me.sof, me.eof, me.idx);
                    else n_pass++;
                end
            end
            st_prev = (bus.data_valid === 1'b1) && (bus.data_ready !== 1'b1);
            pd      = bus.data_out;
            pidx    = 8'(bus.sample_idx);
            psof    = bus.sof;
            peof    = bus.eof;
        end
    end

    // Scoreboard monitor, CP_LEN=0 instance
    exp_t             me0;
    logic             st_prev0 = 1'b0;
    complex_product_t pd0;
    logic [7:0]       pidx0;
    always @(negedge clk) begin
        if (!mon_on) st_prev0 = 1'b0;
        else begin
            if (st_prev0) begin
                n_checks++;
                if (bus0.data_valid !== 1'b1 || bus0.data_out !== pd0 || 8'(bus0.sample_idx) !== pidx0)
                    $display("FAIL stall_hold0: valid=%b re=%0d idx=%0d, required valid=1 re=%0d idx=%0d",
                             bus0.data_valid, bus0.data_out.re, bus0.sample_idx, pd0.re, pidx0);
                else n_pass++;
            end
            if (bus0.data_valid === 1'b1 && bus0.data_ready === 1'b1) begin
                n_checks++;
                if (q0.size() == 0)
                    $display("FAIL beat0_unexpected: got re=%0d idx=%0d, required no beat",
                             bus0.data_out.re, bus0.sample_idx);
                else begin
                    me0 = q0.pop_front();
                    if (bus0.data_out.re !== me0.re || bus0.data_out.im !== me0.im || bus0.sof !== me0.sof ||
                        bus0.eof !== me0.eof || 8'(bus0.sample_idx) !== me0.idx)
                        $display("FAIL beat0: got re=%0d im=%0d sof=%b eof=%b idx=%0d, required re=%0d im=%0d sof=%b eof=%b idx=%0d",
                                 bus0.data_out.re, bus0.data_out.im, bus0.sof, bus0.eof, bus0.sample_idx,
                                 me0.re, me0.im, me0.sof, me0.eof, me0.idx);
                    else n_pass++;
                end
            end
            st_prev0 = (bus0.data_valid === 1'b1) && (bus0.data_ready !== 1'b1);
            pd0      = bus0.data_out;
            pidx0    = 8'(bus0.sample_idx);
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        rmode = 0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        @(negedge clk);
        n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", bus.data_valid); else n_pass++;
        n_checks++; if (bus.sof !== 1'b0) $display("FAIL reset_sof: got %b required 0", bus.sof); else n_pass++;
        n_checks++; if (bus.eof !== 1'b0) $display("FAIL reset_eof: got %b required 0", bus.eof); else n_pass++;
        n_checks++; if (bus.sample_idx !== '0) $display("FAIL reset_idx: got %0d required 0", bus.sample_idx); else n_pass++;
        n_checks++; if (bus.data_out !== '0) $display("FAIL reset_data: got %h required 0", bus.data_out); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", bus.overflow); else n_pass++;
        n_checks++; if (bus.frame_ready !== 1'b1) $display("FAIL reset_frame_ready: got %b required 1", bus.frame_ready); else n_pass++;
        n_checks++; if (bus0.frame_ready !== 1'b1) $display("FAIL reset_frame_ready0: got %b required 1", bus0.frame_ready); else n_pass++;
        mon_on = 1'b1;
    endtask

    task automatic test_single();
        rmode = 1;
        tick();
        drive_frame(1'b0, 0);
        push_exp(1'b0, 0, CP);
        tick();
        bus.frame_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL latency_t1: valid got %b required 0", bus.data_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.sample_idx !== '0 || bus.sof !== 1'b1)
            $display("FAIL latency_t2: valid=%b idx=%0d sof=%b required 1/0/1", bus.data_valid, bus.sample_idx, bus.sof);
        else n_pass++;
        wait_drain("single", 40);
    endtask

    task automatic test_stall();
        rmode = 2;
        tick();
        drive_frame(1'b0, 0);
        push_exp(1'b0, 0, CP);
        tick();
        bus.frame_valid = 1'b0;
        wait_drain("stall", 300);
    endtask

    task automatic test_back_to_back();
        int i   = 0;
        int run = 0;
        rmode = 1;
        tick();
        drive_frame(1'b0, 10);
        push_exp(1'b0, 10, CP);
        tick();
        drive_frame(1'b0, 20);
        push_exp(1'b0, 20, CP);
        tick();
        bus.frame_valid = 1'b0;
        @(negedge clk);
        while (bus.data_valid !== 1'b1 && i < 10) begin
            @(negedge clk);
            i++;
        end
        while (bus.data_valid === 1'b1 && run < 40) begin
            run++;
            @(negedge clk);
        end
        n_checks++;
        if (run != 20) $display("FAIL b2b_contiguous: got %0d contiguous valid beats required 20", run);
        else n_pass++;
        wait_drain("b2b", 40);
    endtask

    task automatic test_overflow();
        rmode = 0;
        tick();
        drive_frame(1'b0, 30);
        push_exp(1'b0, 30, CP);
        tick();
        drive_frame(1'b0, 40);
        push_exp(1'b0, 40, CP);
        tick();
        drive_frame(1'b0, 60);
        @(negedge clk);
        n_checks++; if (bus.frame_ready !== 1'b0) $display("FAIL ovf_frame_ready: got %b required 0", bus.frame_ready); else n_pass++;
        tick();
        bus.frame_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag: got %b required 1", bus.overflow); else n_pass++;
        n_checks++;
        if (bus.data_valid !== 1'b1 || bus.sample_idx !== '0 || bus.sof !== 1'b1)
            $display("FAIL ovf_stalled_head: valid=%b idx=%0d sof=%b required 1/0/1", bus.data_valid, bus.sample_idx, bus.sof);
        else n_pass++;
        repeat (5) tick();
        rmode = 1;
        wait_drain("overflow", 60);
        n_checks++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky: got %b required 1", bus.overflow); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int i = 0;
        rmode  = 1;
        mon_on = 1'b0;
        tick();
        drive_frame(1'b0, 70);
        tick();
        drive_frame(1'b0, 80);
        tick();
        bus.frame_valid = 1'b0;
        @(negedge clk);
        while (!(bus.data_valid === 1'b1 && bus.sample_idx == 4) && i < 20) begin
            @(negedge clk);
            i++;
        end
        n_checks++; if (i >= 20) $display("FAIL rst_mid_reach: sample_idx 4 not seen, got %0d", bus.sample_idx); else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL rst_mid_valid: got %b required 0", bus.data_valid); else n_pass++;
        n_checks++; if (bus.overflow !== 1'b0) $display("FAIL rst_mid_overflow: got %b required 0", bus.overflow); else n_pass++;
        n_checks++; if (bus.frame_ready !== 1'b1) $display("FAIL rst_mid_frame_ready: got %b required 1", bus.frame_ready); else n_pass++;
        q.delete();
        q0.delete();
        mon_on = 1'b1;
        repeat (8) tick();
        drive_frame(1'b0, 90);
        push_exp(1'b0, 90, CP);
        tick();
        bus.frame_valid = 1'b0;
        wait_drain("rst_mid", 40);
    endtask

    task automatic test_no_cp();
        rmode = 1;
        tick();
        drive_frame(1'b1, 0);
        push_exp(1'b1, 0, 0);
        tick();
        bus0.frame_valid = 1'b0;
        wait_drain("no_cp", 40);
    endtask

    initial begin
        reset            = 1'b0;
        bus.frame_valid  = 1'b0;
        bus.frame_in     = '0;
        bus.data_ready   = 1'b0;
        bus0.frame_valid = 1'b0;
        bus0.frame_in    = '0;
        bus0.data_ready  = 1'b0;
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        test_no_cp();
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule
